// File: rtl/led7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one led7_decoder.
// Define LED7_LZB_EN to enable leading-zero blanking; the default build shows every digit.
module led7_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  dec_on,
  output logic [3:0]            dec_in,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PENULT    = CW'(SCAN_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST      = IW'(DIGITS - 1);
  localparam bit            SHOW_ONE      = ((SCAN_DIV - BLANK_CYC) == 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_next;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] active_next;
  logic [DIGITS-1:0]   lzb_mask;
  logic                last_slot;
  logic                boundary;

  // A frame starts either when scanning leaves IDLE or on the last SHOW cycle of the last digit;
  // only there may `active` change, so a frame never mixes two values.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned (no latch).
  always_comb begin
    last_slot   = (state == SHOW) && (idx == IDX_LAST) && (cnt == CNT_LAST);
    boundary    = enable && ((state == IDLE) || last_slot);
    idx_next    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    active_next = active;
    if (boundary) begin
      if (load)         active_next = din;
      else if (pending) active_next = shadow;
    end
  end

`ifdef LED7_LZB_EN
  // A digit is blanked while it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    lzb_mask = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (active[4*i +: 4] == 4'h0);
      lzb_mask[i] = zero_run;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      active <= active_next;
      if (load && !boundary) begin
        shadow  <= din;
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      dec_on     <= 1'b0;
      dec_in     <= 4'h0;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      dec_on     <= 1'b0;
      dec_in     <= 4'h0;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          state     <= BLANK;
          cnt       <= '0;
          idx       <= '0;
          digit_sel <= '1;
          dec_on    <= 1'b0;
          dec_in    <= active_next[3:0];
        end
        BLANK: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_BLANK_END) begin
            state      <= SHOW;
            digit_sel  <= ~(DIGITS'(1) << idx);
            dec_on     <= ~lzb_mask[idx];
            dec_in     <= active[4*idx +: 4];
            frame_done <= (idx == IDX_LAST) && SHOW_ONE;
          end
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            state     <= BLANK;
            cnt       <= '0;
            idx       <= idx_next;
            digit_sel <= '1;
            dec_on    <= 1'b0;
            dec_in    <= active_next[4*idx_next +: 4];
          end else begin
            cnt        <= cnt + 1'b1;
            // Flag the final cycle of the frame while entering it, keeping the output registered.
            frame_done <= (idx == IDX_LAST) && (cnt == CNT_PENULT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Randomized bench for led7_scan_ctrl checked against a timeline model of the scan.
// Define LED7_LZB_EN for both bench and RTL to check leading-zero blanking.
module tb_led7_scan_ctrl;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int B  = 2;
  localparam int FR = D * SD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [4*D-1:0] din = '0;
  logic          dec_on;
  logic [3:0]    dec_in;
  logic [D-1:0]  digit_sel;
  logic          frame_done;
  logic          pending;

  led7_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .din        (din),
    .dec_on     (dec_on),
    .dec_in     (dec_in),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: t counts cycles since scanning started; digit and phase follow by division.
  bit          running = 1'b0;
  int          t = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_shd = '0;
  bit          m_pend = 1'b0;

  function automatic logic [3:0] nib(input logic [15:0] w, input int i);
    return 4'((w >> (4 * i)) & 16'hF);
  endfunction

  function automatic bit lzb_dark(input logic [15:0] w, input int dig);
`ifdef LED7_LZB_EN
    if (dig == 0) return 1'b0;
    for (int j = dig; j < D; j++)
      if (nib(w, j) != 4'h0) return 1'b0;
    return 1'b1;
`else
    return (w == 16'hx) && (dig < 0);
`endif
  endfunction

  task automatic model_reset();
    running = 1'b0;
    t       = 0;
    m_act   = '0;
    m_shd   = '0;
    m_pend  = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input logic [15:0] d);
    bit bnd;
    bnd = 1'b0;
    if (!en) begin
      running = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      t       = 0;
      bnd     = 1'b1;
    end else begin
      t++;
      bnd = (t % FR == 0);
    end
    if (bnd) begin
      if (ld)          m_act = d;
      else if (m_pend) m_act = m_shd;
      m_pend = 1'b0;
    end else if (ld) begin
      m_shd  = d;
      m_pend = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int phase;
    int dig;
    if (!running) begin
      check("idle_sel", 32'(digit_sel), 32'hF);
      check("idle_on", 32'(dec_on), 32'h0);
      check("idle_fd", 32'(frame_done), 32'h0);
      check("idle_pend", 32'(pending), 32'(m_pend));
    end else begin
      phase = t % SD;
      dig   = (t / SD) % D;
      if (phase < B) begin
        check("blank_sel", 32'(digit_sel), 32'hF);
        check("blank_on", 32'(dec_on), 32'h0);
      end else begin
        check("show_sel", 32'(digit_sel), 32'((~(4'b0001 << dig)) & 4'hF));
        check("show_on", 32'(dec_on), 32'(!lzb_dark(m_act, dig)));
      end
      check("dec_in", 32'(dec_in), 32'(nib(m_act, dig)));
      check("frame_done", 32'(frame_done), 32'(t % FR == FR - 1));
      check("pending", 32'(pending), 32'(m_pend));
    end
  endtask

  task automatic step(input bit en, input bit ld, input logic [15:0] d);
    enable = en;
    load   = ld;
    din    = d;
    @(posedge clk);
    model_edge(en, ld, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"}, 32'(digit_sel), 32'hF);
    check({tag, "_on"}, 32'(dec_on), 32'h0);
    check({tag, "_in"}, 32'(dec_in), 32'h0);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
    check({tag, "_pend"}, 32'(pending), 32'h0);
  endtask

  initial begin
    logic [15:0] rd;
    bit          ren;
    bit          rld;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    model_reset();

    // Dark while disabled.
    repeat (20) step(1'b0, 1'b0, 16'h0);

    // Load while idle, then scan 1234.
    step(1'b0, 1'b1, 16'h1234);
    repeat (40) step(1'b1, 1'b0, 16'h0);

    // Two loads mid-frame: last value wins at the boundary.
    repeat (5) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h5678);
    repeat (6) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h9999);
    repeat (50) step(1'b1, 1'b0, 16'h0);

    // Load exactly while frame_done is high.
    for (int i = 0; i < 2 * FR && !(running && (t % FR == FR - 1)); i++)
      step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'hFE00);
    repeat (40) step(1'b1, 1'b0, 16'h0);

    // Drop enable during SHOW of digit 2, then re-enable.
    for (int i = 0; i < 2 * FR && !(running && ((t / SD) % D == 2) && (t % SD >= B + 1)); i++)
      step(1'b1, 1'b0, 16'h0);
    repeat (4) step(1'b0, 1'b0, 16'h0);
    repeat (20) step(1'b1, 1'b0, 16'h0);

    // Asynchronous reset mid-scan.
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    enable = 1'b0;
    load   = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Leading-zero pattern.
    step(1'b0, 1'b1, 16'h0070);
    repeat (40) step(1'b1, 1'b0, 16'h0);

    // Random traffic, nibbles biased toward zero.
    for (int n = 0; n < 1500; n++) begin
      for (int j = 0; j < D; j++)
        rd[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 39) != 0);
      rld = ($urandom_range(0, 9) == 0);
      step(ren, rld, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
